// File: rtl/proc_sequencer.sv
// proc_sequencer: feeds instructions from a small program memory to the proc core, one per Run/Done handshake.
// A Done watchdog traps hung cores. Define PROC_SEQ_SINGLE_STEP_EN to add step/step_mode and the PAUSE state.
module proc_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              CLOCK_50,
  input  logic              Rest,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
`ifdef PROC_SEQ_SINGLE_STEP_EN
  input  logic              step,
  input  logic              step_mode,
`endif
  input  logic              Done,
  output logic [DATA_W-1:0] Din,
  output logic              Run,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [15:0]       instr_count
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // FETCH | put mem[pc] on Din and raise Run
  // WAIT  | Din/Run held until Done or watchdog expiry
  // HALT  | last instruction completed
  // ERROR | core hung; pc and Din frozen for inspection
  // PAUSE | single-step only: pc advanced, waiting for step
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HALT,
    S_ERROR
`ifdef PROC_SEQ_SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  localparam logic [ADDR_W:0]   MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [15:0]       WD_LAST = 16'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                run_q, run_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [15:0]         wd_q, wd_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [DATA_W-1:0]   mem_q [2**ADDR_W];

  logic                is_last;
  logic                wd_expired;
  logic                accept_start;
  logic                pause_next;

  assign is_last      = ({1'b0, pc_q} == (len_q - LEN_ONE));
  assign wd_expired   = (wd_q == WD_LAST);
  assign accept_start = start && (state_q == S_IDLE || state_q == S_HALT || state_q == S_ERROR);

`ifdef PROC_SEQ_SINGLE_STEP_EN
  assign pause_next = step_mode;
`else
  assign pause_next = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or posedge Rest) begin
    if (Rest) begin
      state_q <= S_IDLE;
      din_q   <= '0;
      run_q   <= 1'b0;
      pc_q    <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      run_q   <= run_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      len_q   <= len_d;
    end
  end

  // Program memory is deliberately left out of reset so a reset mid-run keeps the program.
  always_ff @(posedge CLOCK_50) begin
    if (load_we && !busy) begin
      mem_q[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT, S_ERROR: begin
        if (accept_start) begin
          state_d = (prog_len == '0) ? S_HALT : S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (Done) begin
          if (is_last) begin
            state_d = S_HALT;
          end else begin
`ifdef PROC_SEQ_SINGLE_STEP_EN
            state_d = pause_next ? S_PAUSE : S_FETCH;
`else
            state_d = S_FETCH;
`endif
          end
        end else if (wd_expired) begin
          state_d = S_ERROR;
        end
      end
`ifdef PROC_SEQ_SINGLE_STEP_EN
      S_PAUSE: begin
        if (step) begin
          state_d = S_FETCH;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    din_d = din_q;
    run_d = run_q;
    pc_d  = pc_q;
    cnt_d = cnt_q;
    wd_d  = wd_q;
    len_d = len_q;
    case (state_q)
      S_IDLE, S_HALT, S_ERROR: begin
        if (accept_start) begin
          pc_d  = '0;
          cnt_d = '0;
          if (prog_len != '0) begin
            len_d = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
          end
        end
      end
      S_FETCH: begin
        din_d = mem_q[pc_q];
        run_d = 1'b1;
        wd_d  = '0;
      end
      S_WAIT: begin
        // Done takes priority over a watchdog expiring on the same edge.
        if (Done) begin
          run_d = 1'b0;
          cnt_d = cnt_q + 16'd1;
          if (!is_last) begin
            pc_d = pc_q + PC_ONE;
          end
        end else if (wd_expired) begin
          run_d = 1'b0;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  assign Din         = din_q;
  assign Run         = run_q;
  assign pc          = pc_q;
  assign instr_count = cnt_q;
  assign halted      = (state_q == S_HALT);
  assign error       = (state_q == S_ERROR);
`ifdef PROC_SEQ_SINGLE_STEP_EN
  assign busy        = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_PAUSE);
`else
  assign busy        = (state_q == S_FETCH) || (state_q == S_WAIT);
`endif

endmodule

// File: tb/tb_proc_sequencer.sv
// Testbench for proc_sequencer: a Done-generating core model plus a Din scoreboard checked on every Run rise.
module tb_proc_sequencer;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              Rest;
  logic              start;
  logic [ADDR_W:0]   prog_len;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              Done;
  logic [DATA_W-1:0] Din;
  logic              Run;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;
  logic              error;
  logic [15:0]       instr_count;
`ifdef PROC_SEQ_SINGLE_STEP_EN
  logic              step;
  logic              step_mode;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q [$];
  logic [15:0] exp_word;
  logic [15:0] prog_basic [5] = '{16'h101C, 16'h32FF, 16'h52FF, 16'h6200, 16'h5201};

  int core_delay = 3;
  int run_cnt    = 0;
  int gap        = 0;
  bit gap_chk    = 1'b1;
  logic run_prev = 1'b0;

  proc_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK_50    (clk),
    .Rest        (Rest),
    .start       (start),
    .prog_len    (prog_len),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
`ifdef PROC_SEQ_SINGLE_STEP_EN
    .step        (step),
    .step_mode   (step_mode),
`endif
    .Done        (Done),
    .Din         (Din),
    .Run         (Run),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .error       (error),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1);
  end

  // Core model: Done pulses core_delay cycles after Run rises (0 = never).
  always @(negedge clk) begin
    if (Run) begin
      run_cnt = run_cnt + 1;
      Done = (core_delay != 0) && (run_cnt == core_delay);
    end else begin
      run_cnt = 0;
      Done = 1'b0;
    end
  end

  // Scoreboard: every Run rise must present the next expected word, after exactly one low busy cycle.
  always @(negedge clk) begin
    if (Rest) begin
      run_prev = 1'b0;
      gap = 0;
    end else begin
      if (Run && !run_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL din_unexpected got Din=%h with no instruction expected", Din);
        end else begin
          exp_word = exp_q.pop_front();
          if (Din !== exp_word) begin
            errors++;
            $display("FAIL din_order got %h expected %h", Din, exp_word);
          end
        end
        if (gap_chk) begin
          checks++;
          if (gap !== 1) begin
            errors++;
            $display("FAIL run_gap got %0d low cycles expected 1", gap);
          end
        end
        gap = 0;
      end else if (!Run && busy) begin
        gap = gap + 1;
      end
      run_prev = Run;
    end
  end

  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    @(negedge clk);
    load_we = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  task automatic do_start(input logic [ADDR_W:0] len);
    @(negedge clk);
    prog_len = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (halted || error) break;
      @(negedge clk);
    end
    checks++;
    if (!(halted || error)) begin
      errors++;
      $display("FAIL %s_timeout got halted=%b error=%b expected one of them set", tag, halted, error);
    end
  endtask

  task automatic test_reset();
    Rest = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({Din, Run, pc, busy, halted, error, instr_count} !== '0) begin
      errors++;
      $display("FAIL reset_state got Din=%h Run=%b pc=%0d busy=%b halted=%b error=%b cnt=%0d expected all 0",
               Din, Run, pc, busy, halted, error, instr_count);
    end
    Rest = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 5; i++) load_word(ADDR_W'(i), prog_basic[i]);
    core_delay = 3;
    for (int i = 0; i < 5; i++) exp_q.push_back(prog_basic[i]);
    @(negedge clk);
    prog_len = 5; start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (Run !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_edge1 got Run=%b busy=%b expected Run=0 busy=1", Run, busy);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (Run !== 1'b1 || Din !== 16'h101C) begin
      errors++;
      $display("FAIL basic_edge2 got Run=%b Din=%h expected Run=1 Din=101c", Run, Din);
    end
    wait_end(100, "basic");
    checks++;
    if (halted !== 1'b1 || pc !== 4'd4 || instr_count !== 16'd5 || Run !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL basic_end got halted=%b pc=%0d cnt=%0d Run=%b error=%b expected 1 4 5 0 0",
               halted, pc, instr_count, Run, error);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_drain got %0d words left expected 0", exp_q.size());
    end
  endtask

  task automatic test_zero_len();
    @(negedge clk);
    prog_len = 0; start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || pc !== 4'd0 || instr_count !== 16'd0) begin
      errors++;
      $display("FAIL zero_len got halted=%b busy=%b pc=%0d cnt=%0d expected 1 0 0 0", halted, busy, pc, instr_count);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (Run !== 1'b0 || halted !== 1'b1) begin
      errors++;
      $display("FAIL zero_len_hold got Run=%b halted=%b expected Run=0 halted=1", Run, halted);
    end
  endtask

  task automatic test_watchdog();
    core_delay = 0;
    exp_q.push_back(16'h101C);
    @(negedge clk);
    prog_len = 5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (Run !== 1'b1) begin
      errors++;
      $display("FAIL wd_run got Run=%b expected 1", Run);
    end
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (error !== 1'b0 || Run !== 1'b1) begin
      errors++;
      $display("FAIL wd_early got error=%b Run=%b at 15 cycles expected error=0 Run=1", error, Run);
    end
    @(posedge clk); #1;
    checks++;
    if (error !== 1'b1 || Run !== 1'b0 || pc !== 4'd0 || Din !== 16'h101C || busy !== 1'b0) begin
      errors++;
      $display("FAIL wd_trip got error=%b Run=%b pc=%0d Din=%h busy=%b expected 1 0 0 101c 0",
               error, Run, pc, Din, busy);
    end
    core_delay = 3;
    exp_q.push_back(16'h101C);
    exp_q.push_back(16'h32FF);
    do_start(2);
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wd_restart got error=%b busy=%b expected error=0 busy=1", error, busy);
    end
    wait_end(60, "wd_restart");
    checks++;
    if (halted !== 1'b1 || instr_count !== 16'd2) begin
      errors++;
      $display("FAIL wd_restart_end got halted=%b cnt=%0d expected 1 2", halted, instr_count);
    end
  endtask

  task automatic test_race();
    core_delay = TIMEOUT;
    exp_q.push_back(16'h101C);
    exp_q.push_back(16'h32FF);
    do_start(2);
    wait_end(100, "race");
    checks++;
    if (halted !== 1'b1 || error !== 1'b0 || instr_count !== 16'd2) begin
      errors++;
      $display("FAIL race_done_wins got halted=%b error=%b cnt=%0d expected 1 0 2", halted, error, instr_count);
    end
    core_delay = TIMEOUT + 1;
    exp_q.push_back(16'h101C);
    do_start(1);
    wait_end(100, "race_late");
    checks++;
    if (error !== 1'b1 || instr_count !== 16'd0) begin
      errors++;
      $display("FAIL race_late got error=%b cnt=%0d expected 1 0", error, instr_count);
    end
    core_delay = 3;
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    core_delay = 10;
    for (int i = 0; i < 3; i++) exp_q.push_back(prog_basic[i]);
    do_start(5);
    for (int i = 0; i < 100; i++) begin
      if (pc == 4'd2 && Run) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_mid_reach got pc=%0d Run=%b expected third instruction running", pc, Run);
    end
    #2;
    Rest = 1'b1;
    #1;
    checks++;
    if (Run !== 1'b0 || busy !== 1'b0 || pc !== 4'd0 || instr_count !== 16'd0 || halted !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got Run=%b busy=%b pc=%0d cnt=%0d halted=%b error=%b expected all 0",
               Run, busy, pc, instr_count, halted, error);
    end
    @(negedge clk);
    Rest = 1'b0;
    core_delay = 3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_drain got %0d words left expected 0", exp_q.size());
    end
  endtask

  task automatic test_load_guard();
    bit seen = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back(prog_basic[i]);
    do_start(5);
    for (int i = 0; i < 20; i++) begin
      if (Run) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL guard_run got Run=%b expected 1", Run);
    end
    load_word(4'd3, 16'hDEAD);
    wait_end(100, "guard_first");
    for (int i = 0; i < 5; i++) exp_q.push_back(prog_basic[i]);
    do_start(5);
    wait_end(100, "guard_second");
    checks++;
    if (instr_count !== 16'd5 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL guard_end got cnt=%0d left=%0d expected 5 0", instr_count, exp_q.size());
    end
  endtask

  task automatic test_load_start_same_edge();
    exp_q.push_back(16'hABCD);
    @(negedge clk);
    load_we = 1'b1; load_addr = 4'd0; load_data = 16'hABCD;
    prog_len = 1; start = 1'b1;
    @(negedge clk);
    load_we = 1'b0; start = 1'b0;
    wait_end(40, "same_edge");
    checks++;
    if (halted !== 1'b1 || instr_count !== 16'd1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL same_edge got halted=%b cnt=%0d left=%0d expected 1 1 0", halted, instr_count, exp_q.size());
    end
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 16; i++) load_word(ADDR_W'(i), 16'hA000 + 16'(i) * 16'h0011);
    for (int i = 0; i < 16; i++) exp_q.push_back(16'hA000 + 16'(i) * 16'h0011);
    do_start(5'd17);
    wait_end(200, "clamp");
    checks++;
    if (halted !== 1'b1 || instr_count !== 16'd16 || pc !== 4'd15 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL clamp got halted=%b cnt=%0d pc=%0d left=%0d expected 1 16 15 0",
               halted, instr_count, pc, exp_q.size());
    end
  endtask

`ifdef PROC_SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    bit held_ok = 1'b1;
    bit seen;
    gap_chk = 1'b0;
    step_mode = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(16'hA000 + 16'(i) * 16'h0011);
    do_start(3);
    for (int k = 1; k <= 2; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (instr_count == 16'(k)) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL step_reach got cnt=%0d expected %0d", instr_count, k);
      end
      held_ok = 1'b1;
      repeat (20) begin
        @(negedge clk);
        if (Run !== 1'b0 || pc !== 4'(k) || busy !== 1'b1) held_ok = 1'b0;
      end
      checks++;
      if (!held_ok) begin
        errors++;
        $display("FAIL step_hold got Run=%b pc=%0d busy=%b expected Run=0 pc=%0d busy=1", Run, pc, busy, k);
      end
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
    end
    wait_end(40, "step");
    checks++;
    if (halted !== 1'b1 || pc !== 4'd2 || instr_count !== 16'd3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL step_end got halted=%b pc=%0d cnt=%0d left=%0d expected 1 2 3 0",
               halted, pc, instr_count, exp_q.size());
    end
    step_mode = 1'b0;
    gap_chk = 1'b1;
  endtask
`endif

  initial begin
    Rest = 1'b1; start = 1'b0; prog_len = '0;
    load_we = 1'b0; load_addr = '0; load_data = '0; Done = 1'b0;
`ifdef PROC_SEQ_SINGLE_STEP_EN
    step = 1'b0; step_mode = 1'b0;
`endif
    test_reset();
    test_basic();
    test_zero_len();
    test_watchdog();
    test_race();
    test_reset_mid();
    test_load_guard();
    test_load_start_same_edge();
    test_clamp();
`ifdef PROC_SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_sequencer.md
Name: proc_sequencer

Overview:
- Autonomous instruction feeder for the 16-bit `proc` core. Replaces hand-timed stimulus of Din/Run.
- Holds a small program memory and issues one instruction at a time on Din with Run high. Waits for the core's Done, then advances the PC.
- Sits between a loader (testbench or host) and `proc`. Detects a hung core with a watchdog.

Parameters:
- ADDR_W, 4, program memory address width (depth = 2**ADDR_W words)
- DATA_W, 16, instruction width; must match proc Din
- TIMEOUT, 16, max cycles in WAIT without Done before ERROR (valid range 2..65535)

Ports:
- CLOCK_50  input  1  system clock, rising-edge
- Rest  input  1  asynchronous, active-high reset
- start  input  1  level, sampled each edge; launches execution from pc=0
- prog_len  input  ADDR_W+1  number of instructions to run; sampled when start is accepted
- load_we  input  1  program write strobe
- load_addr  input  ADDR_W  program write address
- load_data  input  DATA_W  program write data
- Done  input  1  completion flag from proc
- Din  output  DATA_W  instruction to proc
- Run  output  1  run request to proc
- pc  output  ADDR_W  index of current/next instruction
- busy  output  1  high in FETCH or WAIT
- halted  output  1  high in HALT
- error  output  1  high in ERROR
- instr_count  output  16  instructions completed since last start

Behaviour:
- Reset (async, Rest=1):
  - state=IDLE; Din=0, Run=0, pc=0, instr_count=0, busy=halted=error=0, watchdog=0, latched length=0.
  - Program memory contents are not reset.
- All outputs are registered. busy, halted and error are decoded from the state register.
- States: IDLE, FETCH, WAIT, HALT, ERROR.
- IDLE/HALT/ERROR + start=1:
  - prog_len==0: go to HALT; pc=0, instr_count=0.
  - prog_len>0: latch len=prog_len (a value above 2**ADDR_W is clamped to 2**ADDR_W); pc=0, instr_count=0; go to FETCH.
- With start=0, IDLE, HALT and ERROR hold.
- FETCH: Din<=mem[pc], Run<=1, watchdog<=0, go to WAIT. Run rises exactly 2 edges after start is accepted.
- WAIT: Din and Run are held stable.
  - Done=1: Run<=0, instr_count<=instr_count+1 (wraps at 16 bits).
    - If pc==len-1: go to HALT, pc unchanged.
    - Otherwise: pc<=pc+1, go to FETCH.
  - Done=0 and watchdog==TIMEOUT-1: Run<=0, go to ERROR; pc and Din are frozen for debug.
  - Done=0 otherwise: watchdog+1.
- Done and timeout on the same edge: Done wins.
- Run is low for exactly 1 cycle between consecutive instructions, so the proc FSM returns to its idle step.
- Done is ignored outside WAIT.
- load_we is accepted only when busy=0; mem[load_addr]<=load_data. It is dropped silently while busy.
- Load and start on the same edge in IDLE: the write completes and the run starts. FETCH then reads the new data.
- start while busy is ignored (no restart mid-program).
- Rest mid-instruction drops Run asynchronously and returns to IDLE. The program is retained.
- pc arithmetic is modulo 2**ADDR_W. It never wraps in practice because len≤2**ADDR_W.

Optional Feature:
- Macro: PROC_SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit) and input step_mode (1 bit).
  - With step_mode=1, the WAIT→FETCH transition instead enters a PAUSE state, with Run=0 and pc already advanced.
  - PAUSE moves to FETCH on an edge where step=1; busy=1 in PAUSE.
  - The WAIT→HALT path is unaffected.
  - step_mode=0 behaves identically to the macro being undefined.
- Undefined: no step/step_mode ports and no PAUSE state.

Test Plan:
- Basic run:
  - Stimulus: load mem[0..4]=0x101C,0x32FF,0x52FF,0x6200,0x5201; prog_len=5; pulse start. Core model asserts Done 3 cycles after Run rises.
  - Response: Din takes each word in order. Run rises 2 edges after start and is low 1 cycle between instructions. Ends with halted=1, pc=4, instr_count=5, Run=0.
- Zero/clamp length:
  - Stimulus: prog_len=0 with start.
  - Response: HALT next edge, Run never rises, instr_count=0.
  - Stimulus: prog_len=17 with ADDR_W=4.
  - Response: 16 instructions run.
- Watchdog:
  - Stimulus: Done held 0 after start, TIMEOUT=16.
  - Response: error=1 exactly 16 cycles after Run rose; Run=0, pc=0, Din=0x101C held.
  - Stimulus: start again.
  - Response: error clears and the run restarts.
- Done/timeout race:
  - Stimulus: Done asserted in the same cycle the watchdog reaches TIMEOUT-1.
  - Response: instruction completes and error stays 0.
- Reset and load guard:
  - Stimulus: Rest pulsed mid-WAIT of the third instruction.
  - Response: Run=0 immediately; state IDLE, pc=0, count=0.
  - Stimulus: load_we during busy.
  - Response: the word is not written (read back by running it).
- Single step (PROC_SEQ_SINGLE_STEP_EN):
  - Stimulus: step_mode=1, 3-instruction program.
  - Response: after each Done, Run stays 0 until step pulses. Without step, pc=1 and busy=1 are held indefinitely.
